spi_xfer_arbiter: RTL and testbench

//  Shares one SPI master bus between two requesters in the lac1_clk domain and sequences each frame:
//  CS low, DATA_W mode-0 bits MSB-first, then TAIL_EDGES flush pulses with CS still low, then a CS-high guard gap.
//  The flush pulses clock the downstream 7-stage SCLK-edge CS-delay shifter.

---
 rtl/spi_xfer_arbiter_if.sv | 41 ++++
 rtl/spi_xfer_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_spi_xfer_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_xfer_arbiter_if.sv
// Purpose: requester handshakes and SPI pins shared by spi_xfer_arbiter and its environment.
// Latency: none, wires only.
// Backpressure: reqN_ready is the only accept signal; a request waits while valid and not ready.
// Ports: req0_*/req1_* requester sides, grant/busy status, sclk_out/cs_out/mosi/miso_in SPI pins.
// Modport slave is the arbiter side; modport master is the requester/pin side.
interface spi_xfer_arbiter_if #(
  parameter int DATA_W = 16
);
  logic              req0_valid;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_ready;
  logic              req0_done;
  logic [DATA_W-1:0] req0_rdata;

  logic              req1_valid;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_ready;
  logic              req1_done;
  logic [DATA_W-1:0] req1_rdata;

  logic [1:0]        grant;
  logic              busy;
  logic              sclk_out;
  logic              cs_out;
  logic              mosi;
  logic              miso_in;

  modport slave (
    input  req0_valid, req0_wdata, req1_valid, req1_wdata, miso_in,
    output req0_ready, req0_done, req0_rdata,
    output req1_ready, req1_done, req1_rdata,
    output grant, busy, sclk_out, cs_out, mosi
  );

  modport master (
    output req0_valid, req0_wdata, req1_valid, req1_wdata, miso_in,
    input  req0_ready, req0_done, req0_rdata,
    input  req1_ready, req1_done, req1_rdata,
    input  grant, busy, sclk_out, cs_out, mosi
  );
endinterface

// File: rtl/spi_xfer_arbiter.sv
// Purpose: two-requester arbiter that owns one SPI master and sequences whole mode-0 frames.
// Latency: accept cycle + CLK_DIV*(1+2*(DATA_W+TAIL_EDGES)) cycles CS low + GUARD_CYC cycles CS high.
// Backpressure: ready only in IDLE; requests made while busy wait, a dropped valid has no effect.
// Ports: lac1_clk, nreset (async active low), bus (spi_xfer_arbiter_if.slave) carrying
//   reqN_valid/wdata/ready/done/rdata, grant (one-hot owner), busy, sclk_out, cs_out, mosi, miso_in.
// Frame: CS low, DATA_W bits MSB first, TAIL_EDGES flush pulses with CS low, then CS high guard.
// Build option: define SPI_ARB_FIXED_PRI_EN for fixed priority (req0 wins ties); default is round-robin.
module spi_xfer_arbiter #(
  parameter int DATA_W     = 16,
  parameter int CLK_DIV    = 5,
  parameter int TAIL_EDGES = 7,
  parameter int GUARD_CYC  = 4
) (
  input  logic               lac1_clk,
  input  logic               nreset,
  spi_xfer_arbiter_if.slave  bus
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam int HW = $clog2(CLK_DIV + 1);
  localparam int TW = (TAIL_EDGES > 0) ? $clog2(TAIL_EDGES + 1) : 1;
  localparam int GW = $clog2(GUARD_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_TAIL,
    S_HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [HW-1:0]     hcnt_q, hcnt_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [GW-1:0]     gcnt_q, gcnt_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic              sclk_q, sclk_d;
  logic              cs_q, cs_d;
  logic              mosi_q, mosi_d;
  logic [1:0]        grant_q, grant_d;
  logic              last_q, last_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic              accept;
  logic              pick1;
  logic              tick;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;

  // Arbitration decision; only meaningful while some valid is high.
`ifdef SPI_ARB_FIXED_PRI_EN
  assign pick1 = ~bus.req0_valid;
`else
  // last_q holds the index granted most recently; on a tie the other one wins.
  assign pick1 = bus.req1_valid & (~bus.req0_valid | ~last_q);
`endif

  // nreset gates the accept so ready stays low for the whole reset pulse.
  assign accept = (state_q == S_IDLE) && nreset && (bus.req0_valid || bus.req1_valid);

  assign tick     = (hcnt_q == HW'(CLK_DIV - 1));
  assign tx_shift = tx_q << 1;
  assign rx_shift = (rx_q << 1) | DATA_W'(bus.miso_in);

  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    bcnt_d   = bcnt_q;
    tcnt_d   = tcnt_q;
    gcnt_d   = gcnt_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    sclk_d   = sclk_q;
    cs_d     = cs_q;
    mosi_d   = mosi_q;
    grant_d  = grant_q;
    last_d   = last_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_SETUP;
          tx_d    = pick1 ? bus.req1_wdata : bus.req0_wdata;
          mosi_d  = tx_d[DATA_W-1];
          cs_d    = 1'b0;
          sclk_d  = 1'b0;
          grant_d = pick1 ? 2'b10 : 2'b01;
          last_d  = pick1;
          hcnt_d  = '0;
          bcnt_d  = '0;
          tcnt_d  = '0;
          rx_d    = '0;
        end
      end

      S_SETUP: begin
        hcnt_d = hcnt_q + HW'(1);
        if (tick) begin
          // First rising edge: slave already presents its MSB.
          hcnt_d  = '0;
          sclk_d  = 1'b1;
          rx_d    = rx_shift;
          bcnt_d  = BW'(1);
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        hcnt_d = hcnt_q + HW'(1);
        if (tick) begin
          hcnt_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
            if (bcnt_q == BW'(DATA_W)) begin
              // Low half after the last data bit belongs to TAIL, so CS low
              // time is the same whether or not flush pulses follow.
              mosi_d  = 1'b0;
              state_d = S_TAIL;
            end else begin
              tx_d   = tx_shift;
              mosi_d = tx_shift[DATA_W-1];
            end
          end else begin
            sclk_d = 1'b1;
            rx_d   = rx_shift;
            bcnt_d = bcnt_q + BW'(1);
          end
        end
      end

      S_TAIL: begin
        hcnt_d = hcnt_q + HW'(1);
        if (tick) begin
          hcnt_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
          end else if (tcnt_q == TW'(TAIL_EDGES)) begin
            // Last low half done: release CS and hand the word back.
            state_d = S_HOLD;
            cs_d    = 1'b1;
            mosi_d  = 1'b0;
            gcnt_d  = '0;
            if (grant_q[0]) begin
              rdata0_d = rx_q;
              done0_d  = 1'b1;
            end
            if (grant_q[1]) begin
              rdata1_d = rx_q;
              done1_d  = 1'b1;
            end
          end else begin
            sclk_d = 1'b1;
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end

      S_HOLD: begin
        gcnt_d = gcnt_q + GW'(1);
        if (gcnt_q == GW'(GUARD_CYC - 1)) begin
          gcnt_d  = '0;
          grant_d = 2'b00;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge lac1_clk or negedge nreset) begin
    if (!nreset) begin
      state_q  <= S_IDLE;
      hcnt_q   <= '0;
      bcnt_q   <= '0;
      tcnt_q   <= '0;
      gcnt_q   <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      sclk_q   <= 1'b0;
      cs_q     <= 1'b1;
      mosi_q   <= 1'b0;
      grant_q  <= 2'b00;
      last_q   <= 1'b1;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      bcnt_q   <= bcnt_d;
      tcnt_q   <= tcnt_d;
      gcnt_q   <= gcnt_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      sclk_q   <= sclk_d;
      cs_q     <= cs_d;
      mosi_q   <= mosi_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign bus.req0_ready = accept & ~pick1;
  assign bus.req1_ready = accept & pick1;
  assign bus.req0_done  = done0_q;
  assign bus.req1_done  = done1_q;
  assign bus.req0_rdata = rdata0_q;
  assign bus.req1_rdata = rdata1_q;
  assign bus.grant      = grant_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.sclk_out   = sclk_q;
  assign bus.cs_out     = cs_q;
  assign bus.mosi       = mosi_q;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Purpose: randomized self-checking bench for spi_xfer_arbiter against a frame-level reference model.
// Latency: samples 2 time units after each falling clock edge, drives inputs right after sampling.
// Backpressure: requesters hold valid until ready, then drop (or keep it for back-to-back frames).
module tb_spi_xfer_arbiter;
  localparam int DW       = 16;
  localparam int CD       = 5;
  localparam int TE       = 7;
  localparam int GC       = 4;
  localparam int CS_LOW   = CD * (1 + 2 * (DW + TE));
  localparam int BUSY_CYC = CS_LOW + GC;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  spi_xfer_arbiter_if #(.DATA_W(DW)) bus();

  spi_xfer_arbiter #(
    .DATA_W(DW), .CLK_DIV(CD), .TAIL_EDGES(TE), .GUARD_CYC(GC)
  ) dut (
    .lac1_clk (clk),
    .nreset   (nreset),
    .bus      (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int m_last = 1;
  logic [DW-1:0] exp_rd [2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference arbitration rule.
  function automatic int pick_owner(input bit v0, input bit v1);
`ifdef SPI_ARB_FIXED_PRI_EN
    return v0 ? 0 : 1;
`else
    if (v0 && v1) return 1 - m_last;
    return v0 ? 0 : 1;
`endif
  endfunction

  task automatic sample();
    @(negedge clk);
    #2;
  endtask

  // Waits for the accept, plays the slave for one frame and checks the whole frame.
  task automatic watch_frame(input logic [DW-1:0] wd, input logic [DW-1:0] sw,
                             input int owner, input int pulse_at, input bit drop);
    int cyc, busy_cyc, cs_low, rises, idx, hold, grant_bad, rdy_bad, tail_bad;
    int done_cnt, other_done, done_hold, dcs_rise;
    logic [6:0] dsh;
    logic dcs_last, prev_sclk, rise;
    logic [DW-1:0] got_mosi, got_rd;
    logic [1:0] exp_g;
    busy_cyc = 0; cs_low = 0; rises = 0; idx = 0; hold = 0; grant_bad = 0; rdy_bad = 0;
    tail_bad = 0; done_cnt = 0; other_done = 0; done_hold = -1; dcs_rise = -1;
    dsh = '1; dcs_last = 1'b1; prev_sclk = 1'b0; got_mosi = '0; got_rd = '0;
    exp_g = (owner == 0) ? 2'b01 : 2'b10;

    #1;
    cyc = 0;
    while (!(bus.req0_ready || bus.req1_ready) && cyc < 1000) begin
      sample();
      cyc++;
    end
    check_val("accept_in_time", (cyc < 1000), 1);
    check_val("ready_owner", {bus.req1_ready, bus.req0_ready}, exp_g);
    check_val("grant_idle_at_accept", bus.grant, 2'b00);
    m_last = owner;
    bus.miso_in = sw[DW-1];

    for (cyc = 0; cyc < 1000; cyc++) begin
      sample();
      if (!bus.busy) break;
      if (cyc == 0 && drop) begin
        if (owner == 0) bus.req0_valid = 1'b0;
        else bus.req1_valid = 1'b0;
      end
      busy_cyc++;
      if (!bus.cs_out) cs_low++;
      else hold++;
      if (bus.grant !== exp_g) grant_bad++;
      if (bus.req0_ready || bus.req1_ready) rdy_bad++;
      rise = bus.sclk_out && !prev_sclk;
      if (rise) begin
        rises++;
        if (rises <= DW) got_mosi = {got_mosi[DW-2:0], bus.mosi};
        else if (bus.mosi !== 1'b0) tail_bad++;
      end
      if (!bus.sclk_out && prev_sclk) idx++;
      bus.miso_in = (idx < DW) ? sw[DW-1-idx] : 1'b0;
      // Downstream 7-stage CS delay: shifts cs_out on SCLK rises, preset while CS is high.
      if (bus.cs_out) dsh = '1;
      else if (rise) dsh = {dsh[5:0], bus.cs_out};
      if (dcs_rise < 0 && !dsh[6]) dcs_rise = rises;
      if (!bus.cs_out) dcs_last = dsh[6];
      if (bus.req0_done || bus.req1_done) begin
        done_cnt++;
        done_hold = hold;
        got_rd = (owner == 0) ? bus.req0_rdata : bus.req1_rdata;
        if ((owner == 0) ? bus.req1_done : bus.req0_done) other_done++;
      end
      if (pulse_at >= 0) begin
        if (busy_cyc == pulse_at) bus.req1_valid = 1'b1;
        else if (busy_cyc == pulse_at + 1) bus.req1_valid = 1'b0;
      end
      prev_sclk = bus.sclk_out;
    end
    check_val("frame_in_time", (cyc < 1000), 1);
    check_val("busy_cycles", busy_cyc, BUSY_CYC);
    check_val("cs_low_cycles", cs_low, CS_LOW);
    check_val("guard_cycles", hold, GC);
    check_val("sclk_rises", rises, DW + TE);
    check_val("mosi_word", got_mosi, wd);
    check_val("tail_mosi_nonzero", tail_bad, 0);
    check_val("done_count", done_cnt, 1);
    check_val("done_on_hold_entry", done_hold, 1);
    check_val("other_done", other_done, 0);
    check_val("rdata_owner", got_rd, sw);
    check_val("grant_during_frame", grant_bad, 0);
    check_val("ready_while_busy", rdy_bad, 0);
    check_val("dcs_low_at_rise", dcs_rise, 7);
    check_val("dcs_low_at_cs_rise", dcs_last, 1'b0);
    check_val("grant_after_frame", bus.grant, 2'b00);
    exp_rd[owner] = sw;
    check_val("rdata0_hold", bus.req0_rdata, exp_rd[0]);
    check_val("rdata1_hold", bus.req1_rdata, exp_rd[1]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad, cyc, rises, own;
    logic prev;
    logic [DW-1:0] w0, w1;
    bus.req0_valid = 1'b0; bus.req0_wdata = '0;
    bus.req1_valid = 1'b0; bus.req1_wdata = '0;
    bus.miso_in = 1'b0;
    exp_rd[0] = '0; exp_rd[1] = '0;

    // Reset state and quiet idle.
    repeat (3) sample();
    check_val("rst_cs", bus.cs_out, 1'b1);
    check_val("rst_sclk", bus.sclk_out, 1'b0);
    check_val("rst_mosi", bus.mosi, 1'b0);
    check_val("rst_busy", bus.busy, 1'b0);
    check_val("rst_grant", bus.grant, 2'b00);
    check_val("rst_done", {bus.req1_done, bus.req0_done}, 2'b00);
    check_val("rst_rdata", {bus.req1_rdata, bus.req0_rdata}, 32'h0);
    nreset = 1'b1;
    bad = 0;
    repeat (50) begin
      sample();
      if (bus.cs_out !== 1'b1 || bus.sclk_out !== 1'b0 || bus.busy !== 1'b0 ||
          bus.grant !== 2'b00 || bus.req0_ready || bus.req1_ready) bad++;
    end
    check_val("idle_quiet", bad, 0);

    // Directed frame from req0.
    bus.req0_wdata = 16'hA5C3;
    bus.req0_valid = 1'b1;
    watch_frame(16'hA5C3, 16'h3C5A, 0, -1, 1'b1);

    // Both requesters held valid for three back-to-back frames.
    w0 = 16'($urandom); w1 = 16'($urandom);
    bus.req0_wdata = w0; bus.req1_wdata = w1;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    for (int f = 0; f < 3; f++) begin
      own = pick_owner(1'b1, 1'b1);
      watch_frame(own ? w1 : w0, 16'($urandom), own, -1, 1'b0);
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;

    // Reset in the middle of SHIFT.
    sample();
    bus.req0_wdata = 16'($urandom);
    bus.req0_valid = 1'b1;
    #1;
    cyc = 0;
    while (!bus.req0_ready && cyc < 100) begin sample(); cyc++; end
    check_val("rst_mid_accept", bus.req0_ready, 1'b1);
    sample();
    bus.req0_valid = 1'b0;
    rises = 0; prev = 1'b0; cyc = 0;
    while (rises < 7 && cyc < 2000) begin
      sample();
      cyc++;
      if (bus.sclk_out && !prev) rises++;
      prev = bus.sclk_out;
    end
    check_val("rst_mid_reach_bit7", rises, 7);
    nreset = 1'b0;
    #1;
    check_val("rst_mid_cs", bus.cs_out, 1'b1);
    check_val("rst_mid_sclk", bus.sclk_out, 1'b0);
    check_val("rst_mid_busy", bus.busy, 1'b0);
    check_val("rst_mid_grant", bus.grant, 2'b00);
    check_val("rst_mid_rdata0", bus.req0_rdata, 16'h0);
    sample();
    nreset = 1'b1;
    m_last = 1;
    exp_rd[0] = '0; exp_rd[1] = '0;
    bad = 0;
    repeat (300) begin
      sample();
      if (bus.req0_done || bus.req1_done || !bus.cs_out || bus.busy) bad++;
    end
    check_val("rst_mid_no_frame", bad, 0);
    bus.req0_wdata = 16'($urandom);
    bus.req0_valid = 1'b1;
    watch_frame(bus.req0_wdata, 16'($urandom), 0, -1, 1'b1);

    // req1 pulses valid for one cycle while busy; must be ignored.
    bus.req0_wdata = 16'($urandom);
    bus.req0_valid = 1'b1;
    watch_frame(bus.req0_wdata, 16'($urandom), 0, 50, 1'b1);
    bad = 0;
    repeat (100) begin
      sample();
      if (bus.busy || bus.req0_ready || bus.req1_ready || bus.grant !== 2'b00) bad++;
    end
    check_val("pulse_ignored", bad, 0);

    // Randomized request mix, losers keep waiting.
    for (int k = 0; k < 6; k++) begin
      if (!bus.req0_valid && $urandom_range(0, 1) == 1) begin
        bus.req0_wdata = 16'($urandom); bus.req0_valid = 1'b1;
      end
      if (!bus.req1_valid && $urandom_range(0, 1) == 1) begin
        bus.req1_wdata = 16'($urandom); bus.req1_valid = 1'b1;
      end
      if (!bus.req0_valid && !bus.req1_valid) begin
        bus.req1_wdata = 16'($urandom); bus.req1_valid = 1'b1;
      end
      own = pick_owner(bus.req0_valid, bus.req1_valid);
      watch_frame(own ? bus.req1_wdata : bus.req0_wdata, 16'($urandom), own, -1, 1'b1);
      if (!bus.req0_valid && !bus.req1_valid) repeat ($urandom_range(0, 3)) sample();
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    repeat (5) sample();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
